// File: rtl/logic16_arbiter_if.sv
// Request/response bundle between the four requesting sequencers, the shared
// logic unit and the writeback path.
interface logic16_arbiter_if;
    logic [3:0]  req_valid;
    logic [7:0]  req_op;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic [3:0]  req_ready;
    logic        resp_valid;
    logic [1:0]  resp_id;
    logic [15:0] resp_data;
    logic        resp_ready;

    modport master (
        output req_valid, req_op, req_a, req_b, resp_ready,
        input  req_ready, resp_valid, resp_id, resp_data
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, resp_ready,
        output req_ready, resp_valid, resp_id, resp_data
    );
endinterface

// File: rtl/logic16_arbiter.sv
// Round-robin shared 16-bit AND/OR/NOT-A/NAND unit for four requesters with a
// one-entry valid/ready result register.
module logic16_arbiter (
    input logic               clk,
    input logic               rst_n,
    logic16_arbiter_if.slave  bus
);
    logic        resp_valid_q, resp_valid_d;
    logic [1:0]  resp_id_q, resp_id_d;
    logic [15:0] resp_data_q, resp_data_d;
    logic [1:0]  ptr_q, ptr_d;

    logic        free;
    logic        any_valid;
    logic        grant;
    logic [1:0]  winner;
    logic [1:0]  scan_idx;
    logic [1:0]  win_op;
    logic [15:0] win_a, win_b, win_res;

    // Scan from ptr+3 down to ptr so the lowest offset with a valid request wins.
    always_comb begin
        any_valid = 1'b0;
        winner    = ptr_q;
        scan_idx  = ptr_q;
        for (int k = 3; k >= 0; k--) begin
            scan_idx = ptr_q + 2'(k);
            if (bus.req_valid[scan_idx]) begin
                any_valid = 1'b1;
                winner    = scan_idx;
            end
        end
    end

    assign free          = !resp_valid_q | bus.resp_ready;
    assign grant         = any_valid & free & rst_n;
    assign bus.req_ready = grant ? (4'b0001 << winner) : 4'b0000;

    assign win_op = bus.req_op[{winner, 1'b0} +: 2];
    assign win_a  = bus.req_a[{winner, 4'b0000} +: 16];
    assign win_b  = bus.req_b[{winner, 4'b0000} +: 16];

    always_comb begin
        win_res = 16'h0000;
        unique case (win_op)
            2'b00: win_res = win_a & win_b;
            2'b01: win_res = win_a | win_b;
            2'b10: win_res = ~win_a;
            2'b11: win_res = ~(win_a & win_b);
            default: win_res = 16'h0000;
        endcase
    end

    // A grant in the same cycle as a drain overwrites the entry without a bubble.
    always_comb begin
        resp_valid_d = resp_valid_q;
        resp_id_d    = resp_id_q;
        resp_data_d  = resp_data_q;
        ptr_d        = ptr_q;
        if (grant) begin
            resp_valid_d = 1'b1;
            resp_id_d    = winner;
            resp_data_d  = win_res;
            ptr_d        = winner + 2'd1;
        end else if (resp_valid_q && bus.resp_ready) begin
            resp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid_q <= 1'b0;
            resp_id_q    <= 2'd0;
            resp_data_q  <= 16'h0000;
            ptr_q        <= 2'd0;
        end else begin
            resp_valid_q <= resp_valid_d;
            resp_id_q    <= resp_id_d;
            resp_data_q  <= resp_data_d;
            ptr_q        <= ptr_d;
        end
    end

    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_id    = resp_id_q;
    assign bus.resp_data  = resp_data_q;
endmodule

// File: doc/logic16_arbiter.md
# logic16_arbiter

Shares a single 16-bit bitwise logic unit (AND/OR/NOT-A/NAND built from the team's 16-bit gate primitives) between four requesters. A round-robin arbiter accepts at most one operation per cycle and computes it. The result is held in a one-entry output register with a valid/ready handshake. The block sits between the requesting sequencers and the downstream writeback path, so no requester needs its own logic unit.

## Interface
- Parameters: none. Data width is fixed at 16; requester count is fixed at 4.
- clk  input  1  system clock; all state changes on the rising edge
- rst_n  input  1  asynchronous, active-low reset
- req_valid  input  4  per-requester request valid; bit i belongs to requester i
- req_op  input  8  per-requester opcode, 2 bits each: [2i+1:2i]
  - 00 = AND
  - 01 = OR
  - 10 = NOT a
  - 11 = NAND
- req_a  input  64  per-requester operand A, [16i+15:16i]
- req_b  input  64  per-requester operand B, [16i+15:16i]; ignored for op 10
- req_ready  output  4  one-hot grant: requester i's request is accepted on the edge where req_valid[i] & req_ready[i]
- resp_valid  output  1  result register holds a valid result
- resp_id  output  2  index of the requester that owns the held result
- resp_data  output  16  held result
- resp_ready  input  1  downstream accepts the result on the edge where resp_valid & resp_ready

## Operation
- State:
  - output register: resp_valid, resp_id, resp_data
  - round-robin pointer ptr[1:0]: the highest-priority requester index
- Free condition: `free = !resp_valid | resp_ready`.
- Arbitration is combinational from req_valid, ptr and free:
  - If free, scan indices ptr, ptr+1, ptr+2, ptr+3 (mod 4). The first i with req_valid[i]=1 is the winner; req_ready = one-hot(winner).
  - If not free, or no req_valid bit is set, req_ready = 0000.
  - req_ready never has more than one bit set.
  - req_ready may depend combinationally on req_valid. Requesters must not make req_valid depend on req_ready.
- On a grant edge (winner w):
  - resp_data ← op(req_a[w], req_b[w]), computed bitwise over all 16 bits
  - resp_id ← w
  - resp_valid ← 1
  - ptr ← w+1 mod 4; wraps from 3 to 0
- On an edge where resp_valid & resp_ready and there is no grant: resp_valid ← 0. resp_id and resp_data keep their values.
- Simultaneous drain and grant in the same cycle: the new result replaces the old one and resp_valid stays 1. No bubble.
- With no grant, ptr is unchanged.
- While resp_valid=1 and resp_ready=0: resp_id and resp_data are stable, and req_ready=0000 (backpressure).
- Fairness: a requester holding req_valid high is granted within 4 grants.
- Requester-side rule: once req_valid is asserted, hold it, and keep req_op/req_a/req_b stable, until accepted.

## Timing
- Reset (rst_n=0), asynchronous, takes effect immediately:
  - resp_valid=0, resp_id=0, resp_data=16'h0000, ptr=0
  - req_ready=0000 while rst_n=0
- Reset mid-operation discards any held result. No response is replayed after reset.
- Release: state leaves reset at the first rising edge after rst_n=1. Requests may be granted in that same first cycle.
- Latency:
  - request accepted at edge N → resp_valid=1 with the result visible after edge N
  - result can drain at edge N+1
- Throughput: one operation per cycle while resp_ready=1.
- Combinational paths:
  - req_valid → req_ready
  - resp_ready → req_ready
  - There is no path from request operands to resp_*.

## Test plan
- Reset values: drive rst_n=0 mid-stream with resp_valid=1 → resp_valid, resp_id and resp_data drop to 0 without a clock edge. After release, the first grant goes to requester 0 when all four are valid.
- Single op sweep: requester 2 only, a=16'hF0F0, b=16'hFF00, resp_ready=1, ops 00/01/10/11 → resp_data = 16'hF000, 16'hFFF0, 16'h0F0F, 16'h0FFF; resp_id=2 each time; each result appears one cycle after its grant.
- Round-robin: all four valid continuously, resp_ready=1 → grant order 0,1,2,3,0,1; one grant per cycle; req_ready always one-hot.
- Pointer skip: ptr=2 with only requesters 0 and 1 valid → requester 0 granted and ptr becomes 1; requester 1 is granted next cycle.
- Backpressure: result held with resp_ready=0 for 5 cycles while requesters 1 and 3 are valid → req_ready=0000 and resp_data/resp_id stable throughout. On the cycle resp_ready=1, a new grant occurs and resp_valid stays 1 with the new result (no bubble).
- Drain without refill: resp_valid=1, resp_ready=1, no requests → resp_valid=0 next cycle; resp_data keeps its last value.
